seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of BCD digits scanned.
REQ-002 The block SHALL have parameter REFRESH_DIV, default 100000, meaning the number of clk cycles each digit is enabled; legal values are >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port bcd_in, input, DIGITS*4 bits: packed BCD digits, digit j at bits [j*4 +: 4], digit 0 least significant.
REQ-006 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures bcd_in.
REQ-007 The block SHALL have port an, output, DIGITS bits: active-low digit enables.
REQ-008 The block SHALL have port seg, output, 7 bits: active-low segments, ordered {g,f,e,d,c,b,a}.

Function
REQ-009 On each clk edge with load=1, the block SHALL capture bcd_in into a shadow register.
REQ-010 The block SHALL hold a display register; it SHALL copy the shadow register into the display register only on the edge where the digit index wraps from DIGITS-1 to 0 (frame boundary).
REQ-011 When load=1 coincides with a frame-boundary edge, the display register SHALL take bcd_in directly on that edge, so the new value shows in the new frame.
REQ-012 The block SHALL contain a refresh counter that counts 0..REFRESH_DIV-1 and wraps to 0; its width SHALL be $clog2(REFRESH_DIV).
REQ-013 When the counter equals REFRESH_DIV-1, the digit index SHALL advance on that edge; index DIGITS-1 SHALL wrap to 0.
REQ-014 The frame length SHALL be exactly DIGITS*REFRESH_DIV cycles.
REQ-015 The outputs an and seg SHALL be registered and SHALL reflect the index and display register one cycle after they change (latency 1).
REQ-016 Exactly one an bit SHALL be low outside reset: an[k]=0 for the current index k.
REQ-017 The seg output SHALL decode the digit as follows: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-018 The seg output SHALL display BCD nibbles 10..15 (invalid) as a dash, 0111111 (only g lit).
REQ-019 A load arriving mid-frame SHALL NOT alter the digits of the current frame; this prevents tearing.

Reset
REQ-020 While rst_n=0, the block SHALL force an=all ones, seg=1111111, counter=0, index=0, and the shadow and display registers to 0.
REQ-021 Reset SHALL take effect immediately, independent of clk, including mid-frame; any pending load SHALL be lost.
REQ-022 On the first clk edge after rst_n rises, the block SHALL drive an[0]=0 and seg=1000000 (digit 0 showing "0").

Configuration
REQ-023 The macro LEADING_ZERO_BLANK_EN SHALL control leading-zero blanking as follows.
REQ-024 With LEADING_ZERO_BLANK_EN defined, the block SHALL blank a display digit (seg=1111111, its an bit still asserted) if it and all more-significant digits equal 0; digit 0 SHALL never be blanked.
REQ-025 Without LEADING_ZERO_BLANK_EN, the block SHALL decode all digits normally per REQ-017/REQ-018.

Verification
(DIGITS=4, REFRESH_DIV=4.)
REQ-026 The bench SHALL cover: reset release, no load -> an cycles 1110,1101,1011,0111 with 4 cycles each; seg=1000000 throughout (without the macro).
REQ-027 The bench SHALL cover: load bcd_in=16'h1234 at frame cycle 5 -> the current frame stays 0000; the next frame shows digit0=0011001 ("4"), digit1=0110000, digit2=0100100, digit3=1111001.
REQ-028 The bench SHALL cover: load 16'h5678 on the exact wrap edge -> the new frame immediately shows "8","7","6","5".
REQ-029 The bench SHALL cover: load 16'h00A7 -> digit1 shows dash 0111111; digit0 shows "7"; digits 2 and 3 show "0".
REQ-030 The bench SHALL cover: with LEADING_ZERO_BLANK_EN, load 16'h0040 -> digits 3 and 2 are 1111111, digit1 is "4", digit0 is "0"; load 16'h0000 -> only digit0 is "0".
REQ-031 The bench SHALL cover: assert rst_n=0 mid-frame while showing 1234 -> an=1111 and seg=1111111 immediately; after release the display shows 0000 from digit 0.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Multiplexed BCD seven-segment scanner with frame-synchronous display updates.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps

module seven_seg_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIGITS*4-1:0]   bcd_in,
    input  logic                  load,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [DIGITS*4-1:0] shadow;
    logic [DIGITS*4-1:0] disp;
    logic                cnt_wrap;
    logic                frame_wrap;
    logic [3:0]          digit;
    logic                blank;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign cnt_wrap   = (cnt == CNT_MAX);
    assign frame_wrap = cnt_wrap && (idx == IDX_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt_wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (cnt_wrap) begin
            if (idx == IDX_MAX) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // The display only changes at frame boundaries so a frame never mixes old and
    // new digits; a load on the boundary edge itself bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            disp   <= '0;
        end else begin
            if (load) begin
                shadow <= bcd_in;
            end
            if (frame_wrap) begin
                disp <= load ? bcd_in : shadow;
            end
        end
    end

    always_comb begin
        digit   = '0;
        an_next = '1;
        for (int j = 0; j < DIGITS; j++) begin
            if (idx == IDX_W'(j)) begin
                digit      = disp[j*4 +: 4];
                an_next[j] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] zero_up;

    // zero_up[j] is set when digit j and every more-significant digit are zero.
    always_comb begin
        zero_up             = '0;
        zero_up[DIGITS-1]   = (disp[(DIGITS-1)*4 +: 4] == 4'd0);
        for (int j = DIGITS - 2; j >= 0; j--) begin
            zero_up[j] = (disp[j*4 +: 4] == 4'd0) && zero_up[j+1];
        end
        blank = 1'b0;
        for (int j = 1; j < DIGITS; j++) begin
            if (idx == IDX_W'(j)) begin
                blank = zero_up[j];
            end
        end
    end
`else
    assign blank = 1'b0;
`endif

    assign seg_next = blank ? SEG_OFF : decode(digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= SEG_OFF;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner (DIGITS=4, REFRESH_DIV=4, 16-cycle frames).
// Expectations follow LEADING_ZERO_BLANK_EN when the macro is defined.
`timescale 1ns/1ps

module tb_seven_seg_scanner;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_LZ   = SEG_OFF;
`else
    localparam logic [6:0] SEG_LZ   = SEG_0;
`endif

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        load   = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic [3:0]  an;
    logic [6:0]  seg;

    int checks = 0;
    int errors = 0;

    seven_seg_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bcd_in (bcd_in),
        .load   (load),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [6:0] observed, input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    // One full 16-tick frame; a load can be raised after tick load_at so that it
    // is captured on the following rising edge.
    task automatic run_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3,
                             input int load_at, input logic [15:0] load_val);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an  [4];
        exp_seg = '{s0, s1, s2, s3};
        exp_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_output($sformatf("%s an t%0d", tag, i), {3'b000, an}, {3'b000, exp_an[i/4]});
            check_output($sformatf("%s seg t%0d", tag, i), seg, exp_seg[i/4]);
            if (i == load_at) begin
                load   = 1'b1;
                bcd_in = load_val;
            end else begin
                load   = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting seven_seg_scanner bench");
        repeat (3) @(negedge clk);
        check_output("reset an", {3'b000, an}, 7'b0001111);
        check_output("reset seg", seg, SEG_OFF);
        rst_n = 1'b1;
        check_output("release an", {3'b000, an}, 7'b0001111);

        run_frame("f0 idle",     SEG_0,  SEG_LZ, SEG_LZ, SEG_LZ,  -1, 16'h0000);
        run_frame("f1 midload",  SEG_0,  SEG_LZ, SEG_LZ, SEG_LZ,   4, 16'h1234);
        run_frame("f2 1234",     SEG_4,  SEG_3,  SEG_2,  SEG_1,   14, 16'h5678);
        run_frame("f3 5678",     SEG_8,  SEG_7,  SEG_6,  SEG_5,    3, 16'h00A7);
        run_frame("f4 00A7",     SEG_7,  SEG_DASH, SEG_LZ, SEG_LZ, 3, 16'h0040);
        run_frame("f5 0040",     SEG_0,  SEG_4,  SEG_LZ, SEG_LZ,   3, 16'h0000);
        run_frame("f6 0000",     SEG_0,  SEG_LZ, SEG_LZ, SEG_LZ,   3, 16'h1234);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_output($sformatf("f7 an t%0d", i), {3'b000, an}, (i < 4) ? 7'b0001110 : 7'b0001101);
            check_output($sformatf("f7 seg t%0d", i), seg, (i < 4) ? SEG_4 : SEG_3);
            if (i == 4) begin
                load   = 1'b1;
                bcd_in = 16'h9999;
            end else begin
                load   = 1'b0;
            end
        end

        #2 rst_n = 1'b0;
        #1;
        check_output("async reset an", {3'b000, an}, 7'b0001111);
        check_output("async reset seg", seg, SEG_OFF);
        @(negedge clk);
        check_output("held reset an", {3'b000, an}, 7'b0001111);
        check_output("held reset seg", seg, SEG_OFF);
        rst_n = 1'b1;

        run_frame("r0 zeros",    SEG_0,  SEG_LZ, SEG_LZ, SEG_LZ,  -1, 16'h0000);
        run_frame("r1 zeros",    SEG_0,  SEG_LZ, SEG_LZ, SEG_LZ,  -1, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
